uart_cmd_holder: RTL and testbench

Converts controller command bytes from the UART receiver into stable, glitch-free player-input levels and one-cycle press pulses in the 108 MHz game domain. It sits between the UART receiver (byte plus valid, produced in the 3.226 MHz domain) and the game top, replacing the purely combinational byte decode. It synchronises the valid strobe, checks parity, resolves left/right conflicts, holds the last good command, and releases all inputs when the link goes silent.

---
 rtl/uart_cmd_holder.sv | 179 +++++++++++++++++
 tb/tb_uart_cmd_holder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_holder.sv
// Turns UART controller command bytes into held player-input levels and press pulses
// in the 108 MHz game domain, with parity rejection, left/right resolution and link timeout.
module uart_cmd_holder #(
    parameter int unsigned TIMEOUT_CYC = 32'd10_800_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_right,
    output logic       o_left,
    output logic       o_jump,
    output logic       o_squat,
    output logic       o_attack,
    output logic       o_defend,
    output logic       o_select,
    output logic       o_jump_p,
    output logic       o_attack_p,
    output logic       o_select_p,
    output logic       o_link_lost,
    output logic [7:0] o_err_cnt
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 32'd1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT_CYC - 32'd2);

    typedef enum logic [0:0] {
        LINK_LOST = 1'b0,
        LINKED    = 1'b1
    } link_state_t;

    function automatic logic parity_even_ok(input logic [7:0] b);
        return ~(^b);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : (v + 8'd1);
    endfunction

    // Both directions pressed at once cancel each other out.
    function automatic logic [6:0] resolve_socd(input logic [6:0] cmd);
        logic [6:0] r;
        r = cmd;
        if (cmd[0] && cmd[1]) begin
            r[1:0] = 2'b00;
        end else begin
            r[1:0] = cmd[1:0];
        end
        return r;
    endfunction

    logic              vld_s1_r;
    logic              vld_s2_r;
    logic              vld_s3_r;
    logic              rise_s;
    logic              pkt_acc_s;
    logic              pkt_rej_s;
    logic              tmo_hit_s;
    logic [CNT_W-1:0]  tmo_cnt_r;
    logic [CNT_W-1:0]  tmo_cnt_nxt_s;
    link_state_t       state_r;
    link_state_t       state_nxt_s;
    logic [6:0]        levels_r;
    logic [6:0]        levels_nxt_s;
    logic [6:0]        cmd_s;
    logic [2:0]        pulse_r;
    logic [2:0]        pulse_nxt_s;
    logic              link_lost_r;
    logic [7:0]        err_cnt_r;
    logic [7:0]        err_cnt_nxt_s;

    // Valid strobe synchroniser; i_data is stable by the time s2 rises.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_s1_r <= 1'b0;
            vld_s2_r <= 1'b0;
            vld_s3_r <= 1'b0;
        end else begin
            vld_s1_r <= i_valid;
            vld_s2_r <= vld_s1_r;
            vld_s3_r <= vld_s2_r;
        end
    end

    assign rise_s    = vld_s2_r & ~vld_s3_r;
    assign pkt_acc_s = rise_s & parity_even_ok(i_data);
    assign pkt_rej_s = rise_s & ~parity_even_ok(i_data);
    assign tmo_hit_s = ~pkt_acc_s & (tmo_cnt_r == CNT_PRE);
    assign cmd_s     = resolve_socd(i_data[6:0]);

    // Silence counter and parity-error counter next values.
    always_comb begin
        tmo_cnt_nxt_s = tmo_cnt_r;
        err_cnt_nxt_s = err_cnt_r;
        if (pkt_acc_s) begin
            tmo_cnt_nxt_s = '0;
        end else if (tmo_cnt_r < CNT_MAX) begin
            tmo_cnt_nxt_s = tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_nxt_s = tmo_cnt_r;
        end
        if (pkt_rej_s) begin
            err_cnt_nxt_s = sat_inc8(err_cnt_r);
        end else begin
            err_cnt_nxt_s = err_cnt_r;
        end
    end

    // Link FSM next state plus level/pulse updates.
    always_comb begin
        state_nxt_s  = state_r;
        levels_nxt_s = levels_r;
        pulse_nxt_s  = 3'b000;
        case (state_r)
            LINK_LOST: begin
                if (pkt_acc_s) begin
                    state_nxt_s = LINKED;
                end else begin
                    state_nxt_s = LINK_LOST;
                end
            end
            LINKED: begin
                if (tmo_hit_s) begin
                    state_nxt_s = LINK_LOST;
                end else begin
                    state_nxt_s = LINKED;
                end
            end
            default: begin
                state_nxt_s = LINK_LOST;
            end
        endcase
        if (pkt_acc_s) begin
            levels_nxt_s = cmd_s;
            // Pulses compare raw new bits against the level held before this update.
            pulse_nxt_s  = {cmd_s[6] & ~levels_r[6],
                            cmd_s[4] & ~levels_r[4],
                            cmd_s[2] & ~levels_r[2]};
        end else if (tmo_hit_s) begin
            levels_nxt_s = 7'b000_0000;
        end else begin
            levels_nxt_s = levels_r;
        end
    end

    // State, output and counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= LINK_LOST;
            levels_r    <= 7'b000_0000;
            pulse_r     <= 3'b000;
            link_lost_r <= 1'b1;
            tmo_cnt_r   <= '0;
            err_cnt_r   <= 8'h00;
        end else begin
            state_r     <= state_nxt_s;
            levels_r    <= levels_nxt_s;
            pulse_r     <= pulse_nxt_s;
            link_lost_r <= (state_nxt_s == LINK_LOST);
            tmo_cnt_r   <= tmo_cnt_nxt_s;
            err_cnt_r   <= err_cnt_nxt_s;
        end
    end

    assign o_right     = levels_r[0];
    assign o_left      = levels_r[1];
    assign o_jump      = levels_r[2];
    assign o_squat     = levels_r[3];
    assign o_attack    = levels_r[4];
    assign o_defend    = levels_r[5];
    assign o_select    = levels_r[6];
    assign o_jump_p    = pulse_r[0];
    assign o_attack_p  = pulse_r[1];
    assign o_select_p  = pulse_r[2];
    assign o_link_lost = link_lost_r;
    assign o_err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_uart_cmd_holder.sv
// Randomised and directed bench for uart_cmd_holder against a packet-level reference model.
module tb_uart_cmd_holder;

    localparam int TMO = 20;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_right, o_left, o_jump, o_squat, o_attack, o_defend, o_select;
    logic       o_jump_p, o_attack_p, o_select_p, o_link_lost;
    logic [7:0] o_err_cnt;

    uart_cmd_holder #(.TIMEOUT_CYC(TMO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
        .o_right(o_right), .o_left(o_left), .o_jump(o_jump), .o_squat(o_squat),
        .o_attack(o_attack), .o_defend(o_defend), .o_select(o_select),
        .o_jump_p(o_jump_p), .o_attack_p(o_attack_p), .o_select_p(o_select_p),
        .o_link_lost(o_link_lost), .o_err_cnt(o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: levels, pulses, link flag, errors, edge of last accept.
    bit [6:0] m_lvl;
    bit [2:0] m_pls;
    bit       m_lost;
    int       m_err;
    int       ec = 0;
    int       ref_ec;
    bit       last_samp;
    int       apply_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lvl = '0; m_pls = '0; m_lost = 1'b1; m_err = 0;
        apply_q.delete(); last_samp = 1'b0; ref_ec = ec;
    endtask

    // A valid first seen high at edge N takes effect at edge N+2.
    task automatic model_edge();
        bit       acc;
        bit [6:0] nl;
        ec++;
        if (!i_rst_n) begin
            model_reset();
            return;
        end
        m_pls = '0;
        acc = 1'b0;
        if (apply_q.size() > 0 && apply_q[0] == ec) begin
            void'(apply_q.pop_front());
            if ((^i_data) == 1'b0) begin
                acc = 1'b1;
                nl = i_data[6:0];
                if (nl[0] && nl[1]) nl[1:0] = 2'b00;
                m_pls = {i_data[6] & ~m_lvl[6], i_data[4] & ~m_lvl[4], i_data[2] & ~m_lvl[2]};
                m_lvl = nl;
                m_lost = 1'b0;
                ref_ec = ec;
            end else if (m_err < 255) begin
                m_err++;
            end
        end
        if (!acc && (ec - ref_ec) == TMO - 1) begin
            m_lvl = '0;
            m_lost = 1'b1;
        end
        if (i_valid && !last_samp) apply_q.push_back(ec + 2);
        last_samp = i_valid;
    endtask

    task automatic compare_all(input string tag);
        check_eq(tag,
                 {13'd0, o_select, o_defend, o_attack, o_squat, o_jump, o_left, o_right,
                  o_select_p, o_attack_p, o_jump_p, o_link_lost, o_err_cnt},
                 {13'd0, m_lvl, m_pls, m_lost, m_err[7:0]});
    endtask

    task automatic cyc(input bit v, input logic [7:0] d);
        i_valid = v;
        i_data  = d;
        @(posedge i_clk);
        model_edge();
        #1;
        compare_all("outs");
    endtask

    task automatic send(input logic [7:0] d, input int h, input int g);
        repeat (h) cyc(1'b1, d);
        repeat (g) cyc(1'b0, d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int h, g;
        i_rst_n = 1'b0; i_valid = 1'b0; i_data = 8'h00;
        model_reset();
        repeat (3) cyc(1'b0, 8'h00);
        #1 i_rst_n = 1'b1;
        cyc(1'b0, 8'h00);
        check_eq("rst_link_lost", o_link_lost, 1);
        check_eq("rst_err", o_err_cnt, 0);

        // First packet: level appears on the third sampling edge, no pulses.
        cyc(1'b1, 8'h81); cyc(1'b1, 8'h81);
        check_eq("right_early", o_right, 0);
        cyc(1'b1, 8'h81);
        check_eq("right_lat2", o_right, 1);
        check_eq("link_up", o_link_lost, 0);
        check_eq("no_pulse", {o_jump_p, o_attack_p, o_select_p}, 0);
        repeat (3) cyc(1'b0, 8'h81);

        // Jump press, repeat (no pulse), release, press again.
        send(8'h84, 3, 0);
        check_eq("jump_p", o_jump_p, 1);
        cyc(1'b0, 8'h84);
        check_eq("jump_p_1cyc", o_jump_p, 0);
        send(8'h84, 0, 3);
        send(8'h84, 3, 0);
        check_eq("jump_p_rep", o_jump_p, 0);
        send(8'h84, 0, 3);
        send(8'h00, 3, 3);
        send(8'h84, 3, 0);
        check_eq("jump_p_again", o_jump_p, 1);
        send(8'h84, 0, 3);

        // Parity rejects up to saturation.
        send(8'h01, 3, 3);
        check_eq("err1", o_err_cnt, 1);
        check_eq("rej_hold", o_jump, 1);
        repeat (300) send(8'h01, 3, 3);
        check_eq("err_sat", o_err_cnt, 255);

        // Both directions cancel.
        send(8'h03, 3, 0);
        check_eq("socd", {o_right, o_left}, 0);
        send(8'h03, 0, 3);

        // Timeout 19 edges after the update.
        send(8'hF0, 3, 0);
        check_eq("atk_sel_p", {o_attack_p, o_select_p}, 2'b11);
        repeat (18) cyc(1'b0, 8'hF0);
        check_eq("tmo_before", o_link_lost, 0);
        cyc(1'b0, 8'hF0);
        check_eq("tmo_lost", o_link_lost, 1);
        check_eq("tmo_clear", o_attack, 0);
        repeat (3) cyc(1'b0, 8'hF0);

        // Packet lands exactly on the expiry edge.
        send(8'hF0, 3, 16);
        send(8'h84, 3, 0);
        check_eq("tmo_race", o_link_lost, 0);
        check_eq("tmo_race_jump", o_jump, 1);
        send(8'h84, 0, 4);

        // Valid held high: a single strobe only.
        send(8'h84, 40, 4);

        // Reset mid-operation during a valid pulse; valid still high at release.
        send(8'hA0, 3, 3);
        check_eq("defend", o_defend, 1);
        cyc(1'b1, 8'h84);
        #2 i_rst_n = 1'b0;
        model_reset();
        #1 compare_all("async_rst");
        check_eq("rst_defend", o_defend, 0);
        cyc(1'b1, 8'h84); cyc(1'b1, 8'h84);
        i_rst_n = 1'b1;
        cyc(1'b1, 8'h84); cyc(1'b1, 8'h84); cyc(1'b1, 8'h84);
        check_eq("rst_reproc", o_jump, 1);
        send(8'h84, 0, 4);

        // Reset with valid low at release: nothing reprocessed.
        send(8'hA0, 3, 0);
        #2 i_rst_n = 1'b0;
        model_reset();
        cyc(1'b0, 8'hA0);
        i_rst_n = 1'b1;
        repeat (4) cyc(1'b0, 8'hA0);
        check_eq("rst_noreproc", o_defend, 0);

        // Random traffic with mixed parity and gaps around the timeout.
        for (int i = 0; i < 150; i++) begin
            b = 8'($urandom_range(0, 127));
            b[7] = ^b[6:0];
            if ($urandom_range(0, 3) == 0) b[7] = ~b[7];
            h = $urandom_range(3, 6);
            if ($urandom_range(0, 15) == 0) h = 30;
            g = $urandom_range(3, 26);
            send(b, h, g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
